// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: datapath widths, the PC step,
// the default reset PC and the {pc, instr} queue entry type.
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam int          ADDR_W           = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Clears the two byte-offset bits so every fetch address is word aligned.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return addr & ~(ADDR_W'(3));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries. Flush has priority over
// push/pop. The head is kept in its own register so the output holds its
// last value (never X) when the queue is empty, and stays stable while the
// consumer stalls. The caller never pops when empty or pushes when full
// without a simultaneous pop.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         head_valid,
    output fetch_entry_t                 head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    fetch_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [LVL_W-1:0]   count_r;
    fetch_entry_t       head_r;
    fetch_entry_t       head_nxt_s;

    // Storage write port; contents need no reset because only valid slots feed the head.
    always_ff @(posedge clock) begin
        if (push && !flush && !reset) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Selects what the head register shows after this edge.
    always_comb begin
        head_nxt_s = head_r;
        if (flush) begin
            head_nxt_s = head_r;
        end else if (pop && (count_r > LVL_W'(1))) begin
            // Next-oldest entry is already stored; with DEPTH >= 2 it is never the slot being written.
            head_nxt_s = mem_r[rd_ptr_r + PTR_W'(1)];
        end else if (push && ((count_r == LVL_W'(0)) || (pop && (count_r == LVL_W'(1))))) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Pointer, occupancy and head bookkeeping; reset beats flush beats push/pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= LVL_W'(0);
            head_r   <= '0;
        end else if (flush) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= LVL_W'(0);
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + LVL_W'(1);
                2'b01:   count_r <= count_r - LVL_W'(1);
                default: count_r <= count_r;
            endcase
            head_r <= head_nxt_s;
        end
    end

    assign level      = count_r;
    assign head_valid = (count_r != LVL_W'(0));
    assign head       = head_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, addresses i_mem, buffers
// {pc, instr} pairs and hands them to decode over valid/ready. A redirect
// voids that cycle's handshake, flushes the queue and restarts fetch at the
// word-aligned target. Optional macro FETCH_PERF_EN adds perf_fetched
// (pops) and perf_flushed (entries discarded by redirects).
module fetch_queue
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]           imem_data,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTR_W-1:0]           out_instr,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [ADDR_W-1:0]            out_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                  perf_fetched,
    output logic [31:0]                  perf_flushed
`endif
);

    localparam int LVL_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]  fetch_pc_r;
    logic               pop_s;
    logic               push_s;
    logic               full_s;
    logic               head_valid_s;
    logic [LVL_W-1:0]   level_s;
    fetch_entry_t       head_s;
    fetch_entry_t       push_entry_s;

    // Handshake decode: a redirect cancels both the pop and the push of its cycle.
    always_comb begin
        full_s       = (level_s == LVL_W'(DEPTH));
        pop_s        = head_valid_s & out_ready & ~redirect_valid;
        push_s       = ~redirect_valid & (~full_s | pop_s);
        push_entry_s = '{pc: fetch_pc_r, instr: imem_data};
    end

    // Fetch PC: reset, then redirect target, then advance on every push; wraps naturally mod 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_r <= align_word(redirect_pc);
        end else if (push_s) begin
            fetch_pc_r <= fetch_pc_r + PC_STEP;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push_s),
        .push_data  (push_entry_s),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .level      (level_s),
        .head_valid (head_valid_s),
        .head       (head_s)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_flushed_r;

    // Performance counters: completed pops, and occupancy thrown away by each redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched_r <= 32'd0;
            perf_flushed_r <= 32'd0;
        end else begin
            if (pop_s) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushed_r <= perf_flushed_r + 32'(level_s);
            end
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_flushed = perf_flushed_r;
`endif

    assign imem_addr    = fetch_pc_r;
    assign out_valid    = head_valid_s;
    assign out_instr    = head_s.instr;
    assign out_pc       = head_s.pc;
    assign out_pc_plus4 = head_s.pc + PC_STEP;
    assign level        = level_s;

endmodule
